tbus_arbiter: RTL



---
 rtl/tbus_pkg.sv | 23 ++
 rtl/tbus_arbiter_rr_pick.sv | 33 +++
 rtl/tbus_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tbus_pkg.sv
// Shared types and helpers for the TINV bus arbiter.
package tbus_pkg;

    // Arbiter phases: no owner, one owner driving, forced all-off cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } tbus_state_t;

    // Largest requester count the picker and OWNER encoding are sized for.
    localparam int TBUS_MAX_REQ = 8;

    // Width of the OWNER index; never narrower than one bit.
    function automatic int owner_w(input int n_req);
        if (n_req > 2) begin
            return $clog2(n_req);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/tbus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans requesters starting just after
// the last owner and wrapping, returning the first one found.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int OW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [OW-1:0]    last_i,
    output logic [N_REQ-1:0] win_o,
    output logic [OW-1:0]    idx_o,
    output logic             any_o
);

    logic [OW-1:0] cand_s;

    // Walk candidates last+1, last+2, ... so the previous owner is checked last.
    always_comb begin
        win_o  = {N_REQ{1'b0}};
        idx_o  = last_i;
        any_o  = 1'b0;
        cand_s = {OW{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = OW'((int'(last_i) + k) % N_REQ);
            if (!any_o && req_i[cand_s]) begin
                win_o[cand_s] = 1'b1;
                idx_o         = cand_s;
                any_o         = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/tbus_arbiter.sv
// Round-robin owner arbiter for a shared TINV tri-state bus. Drives
// complementary EN/nEN per bank from separate flops, inserts one all-off
// turnaround cycle between owners and preempts long holders.
module tbus_arbiter
    import tbus_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    localparam int OW      = owner_w(N_REQ)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [N_REQ-1:0] EN,
    output logic [N_REQ-1:0] nEN,
    output logic             BUSY,
    output logic [OW-1:0]    OWNER
);

    localparam int HCW = $clog2(MAX_HOLD + 1);
    // Count value at which the current GRANT cycle is the MAX_HOLD-th one.
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] HOLD_SAT  = HCW'(MAX_HOLD);

    tbus_state_t      state_q;
    logic [HCW-1:0]   hold_q;
    logic [OW-1:0]    owner_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] en_q;
    logic [N_REQ-1:0] nen_q;
    logic             busy_q;

    logic [N_REQ-1:0] win_s;
    logic [OW-1:0]    win_idx_s;
    logic             any_s;
    logic             owner_req_s;
    logic             others_s;
    logic             release_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .OW    (OW)
    ) u_pick (
        .req_i  (REQ),
        .last_i (owner_q),
        .win_o  (win_s),
        .idx_o  (win_idx_s),
        .any_o  (any_s)
    );

    // Decide whether the current owner gives up the bus at this edge.
    always_comb begin
        owner_req_s = |(REQ & gnt_q);
        others_s    = |(REQ & ~gnt_q);
        release_d   = 1'b0;
        if (state_q == GRANT) begin
            release_d = !owner_req_s || ((hold_q >= HOLD_LAST) && others_s);
        end else begin
            release_d = 1'b0;
        end
    end

    // Arbiter FSM with all bus-facing outputs held in flops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            hold_q  <= {HCW{1'b0}};
            owner_q <= OW'(N_REQ - 1);
            gnt_q   <= {N_REQ{1'b0}};
            en_q    <= {N_REQ{1'b0}};
            nen_q   <= {N_REQ{1'b1}};
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, TURN: begin
                    if (any_s) begin
                        state_q <= GRANT;
                        hold_q  <= {HCW{1'b0}};
                        owner_q <= win_idx_s;
                        gnt_q   <= win_s;
                        en_q    <= win_s;
                        nen_q   <= ~win_s;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= {N_REQ{1'b0}};
                        en_q    <= {N_REQ{1'b0}};
                        nen_q   <= {N_REQ{1'b1}};
                        busy_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q <= TURN;
                        gnt_q   <= {N_REQ{1'b0}};
                        en_q    <= {N_REQ{1'b0}};
                        nen_q   <= {N_REQ{1'b1}};
                        busy_q  <= 1'b0;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_q  <= hold_q + 1'b1;
                    end else begin
                        hold_q  <= hold_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    hold_q  <= {HCW{1'b0}};
                    gnt_q   <= {N_REQ{1'b0}};
                    en_q    <= {N_REQ{1'b0}};
                    nen_q   <= {N_REQ{1'b1}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT   = gnt_q;
    assign EN    = en_q;
    assign nEN   = nen_q;
    assign BUSY  = busy_q;
    assign OWNER = owner_q;

endmodule
